surf_lbus_master: RTL and testbench
===================================

Name: surf_lbus_master

Overview:
Local-bus initiator that generates single-beat read and write cycles toward the SURF local-bus target. It drives nADS, WnR, LA, nCS2/nCS3, nRD and LD, then waits for nREADY. It sits in the test/bring-up fabric and in the bench harness in place of the PLX bridge, and is driven by a simple request/acknowledge interface. Bursts are not supported; nBTERM is monitored only.

Parameters:
TIMEOUT_CYCLES, 16, max DATA-state cycles waiting for nREADY low before abort (≥2)
TURN_CYCLES, 1, idle cycles inserted after every read before the next nADS (bus turnaround)

Ports:
clk_i  in  1  bus clock, all logic on rising edge
rst_i  in  1  reset, asynchronous, active-high
req_i  in  1  request strobe, sampled only when busy_o=0
wr_i  in  1  1=write, 0=read
space_i  in  2  0=register (nCS2=nCS3=1), 1=HK (nCS2=0), 2=LAB (nCS3=0), 3=reserved (treated as register)
addr_i  in  6  word address, drives LA[7:2]
wdata_i  in  32  write data
busy_o  out  1  high from request accept until end of DONE/TURN
ack_o  out  1  1-cycle pulse, cycle complete
err_o  out  1  1-cycle pulse coincident with ack_o on timeout
rdata_o  out  32  read data, held until next read ack
nADS_o  out  1  address strobe, active low
WnR_o  out  1  1=write
LA_o  out  6  LA[7:2]
nCS2_o  out  1  HK chip select, active low
nCS3_o  out  1  LAB chip select, active low
nRD_o  out  1  read strobe, active low
LD_o  out  32  data out
LD_oe_o  out  1  data output enable (pad tri-state control)
LD_i  in  32  data in from pad
nREADY_i  in  1  target ready, active low
nBTERM_i  in  1  burst terminate, sampled into debug only

Behaviour:
- Reset (async): state IDLE; nADS_o=1, WnR_o=0, nCS2_o=1, nCS3_o=1, nRD_o=1, LA_o=0, LD_o=0, LD_oe_o=0, busy_o=0, ack_o=0, err_o=0, rdata_o=0, counters=0. Reset mid-cycle releases the bus in the same instant; no ack is issued.
- All bus outputs are registered; none is combinational from inputs.
- States: IDLE, ADDR, DATA, DONE, TURN.
- IDLE: on req_i=1, latch wr/space/addr/wdata, set busy_o and go to ADDR. Bus outputs update at that edge. req_i while busy_o=1 is ignored (not queued).
- ADDR: exactly 1 cycle. nADS_o=0, LA_o, WnR_o and chip selects valid. For writes, LD_oe_o=1 and LD_o=wdata from this cycle onward. Go to DATA.
- DATA: nADS_o=1. LA, WnR and CS are held. Reads: nRD_o=0, LD_oe_o=0. Writes: LD driven. nREADY_i is sampled each edge.
  - Sampled low: reads capture LD_i into rdata_o at that edge; go to DONE.
  - Wait counter reaches TIMEOUT_CYCLES: go to DONE with the err flag set.
- DONE: 1 cycle. ack_o=1, err_o=flag. Bus released (nRD=1, CS=1, LD_oe=0, WnR=0). Go to TURN if the cycle was a read and TURN_CYCLES>0, else IDLE. busy_o drops on leaving DONE/TURN.
- TURN: hold released for TURN_CYCLES, then IDLE.
- Latency against a zero-wait target with 1-cycle nREADY: req accept → nADS low 1 cycle later; ack_o ≥3 cycles after accept. Back-to-back writes: new nADS every 4 cycles minimum.
- nREADY_i low while in IDLE/ADDR is ignored.
- A timed-out read leaves rdata_o unchanged.
- Wait counter width is clog2(TIMEOUT_CYCLES+1). It is cleared on entering DATA and saturates.

Decomposition:
- Shared package holds:
  - space encodings SPACE_REG=0, SPACE_HK=1, SPACE_LAB=2
  - state enum constants
  - default TIMEOUT_CYCLES
  - register word addresses: IDENT=0, VERSION=1, HK_CNT=2, LAB_CNT=3, STATUS=4, EVID=5, CTRL=6, MASK=7
- No sub-module is required. The wait/turnaround counter is shared in one always block; a separate lbus_wait_counter is optional only if reused.

Test Plan:
- Register read addr 0, against the SURF target model → nADS low 1 cycle with LA=0, nCS2=nCS3=1; ack_o with rdata_o=0x53555246 ("SURF"), err_o=0.
- Write space 0 addr 7 data 0xDEADBEEF, then read addr 7 → short_mask_o=0xDEADBEEF; read returns 0xDEADBEEF; a TURN cycle precedes the second nADS.
- LAB read space 2 addr 0 with lab_counter=0x005 → nCS3 low, rdata_o=lab_dat_i; target lab_counter increments to 0x006.
- Target model never asserts nREADY → ack_o and err_o pulse together after 16 DATA cycles; rdata_o unchanged; bus released.
- Assert rst_i during DATA of a read → nRD_o, nCS*, LD_oe_o return idle asynchronously; no ack_o; the next request completes normally.
- Issue req_i every cycle for 3 writes → exactly 3 nADS pulses, spaced ≥4 cycles apart; extra req_i while busy is dropped.

Source files
------------

// File: rtl/surf_lbus_master_pkg.sv
// Shared definitions for the SURF local-bus initiator: address spaces, FSM states,
// default timing parameters and target register map.
package surf_lbus_master_pkg;

  localparam logic [1:0] SPACE_REG = 2'd0;
  localparam logic [1:0] SPACE_HK  = 2'd1;
  localparam logic [1:0] SPACE_LAB = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_TURN
  } lbus_state_e;

  localparam int DEF_TIMEOUT_CYCLES = 16;
  localparam int DEF_TURN_CYCLES    = 1;

  localparam logic [5:0] REG_IDENT   = 6'd0;
  localparam logic [5:0] REG_VERSION = 6'd1;
  localparam logic [5:0] REG_HK_CNT  = 6'd2;
  localparam logic [5:0] REG_LAB_CNT = 6'd3;
  localparam logic [5:0] REG_STATUS  = 6'd4;
  localparam logic [5:0] REG_EVID    = 6'd5;
  localparam logic [5:0] REG_CTRL    = 6'd6;
  localparam logic [5:0] REG_MASK    = 6'd7;

  localparam logic [31:0] IDENT_VALUE = 32'h5355_5246;

  // Returns {nCS3, nCS2}; the reserved space falls back to register space.
  function automatic logic [1:0] cs_decode(input logic [1:0] space);
    case (space)
      SPACE_HK:  cs_decode = 2'b10;
      SPACE_LAB: cs_decode = 2'b01;
      default:   cs_decode = 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/surf_lbus_master_if.sv
// Request/acknowledge side and local-bus pins of the SURF initiator, named from the
// initiator's point of view.
interface surf_lbus_master_if;
  import surf_lbus_master_pkg::*;

  logic        req_i;
  logic        wr_i;
  logic [1:0]  space_i;
  logic [5:0]  addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        ack_o;
  logic        err_o;
  logic [31:0] rdata_o;

  logic        nADS_o;
  logic        WnR_o;
  logic [5:0]  LA_o;
  logic        nCS2_o;
  logic        nCS3_o;
  logic        nRD_o;
  logic [31:0] LD_o;
  logic        LD_oe_o;
  logic [31:0] LD_i;
  logic        nREADY_i;
  logic        nBTERM_i;
  logic        nBTERM_dbg_o;

  modport master (
    input  req_i, wr_i, space_i, addr_i, wdata_i, LD_i, nREADY_i, nBTERM_i,
    output busy_o, ack_o, err_o, rdata_o, nADS_o, WnR_o, LA_o, nCS2_o, nCS3_o,
           nRD_o, LD_o, LD_oe_o, nBTERM_dbg_o
  );

  modport slave (
    output req_i, wr_i, space_i, addr_i, wdata_i, LD_i, nREADY_i, nBTERM_i,
    input  busy_o, ack_o, err_o, rdata_o, nADS_o, WnR_o, LA_o, nCS2_o, nCS3_o,
           nRD_o, LD_o, LD_oe_o, nBTERM_dbg_o
  );

endinterface

// File: rtl/surf_lbus_master.sv
// Single-beat local-bus initiator: one ADDR cycle with nADS low, DATA until nREADY or
// timeout, one DONE cycle with ack, and optional turnaround after reads.
module surf_lbus_master
  import surf_lbus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TURN_CYCLES    = DEF_TURN_CYCLES
) (
  input  logic                clk_i,
  input  logic                rst_i,
  surf_lbus_master_if.master  bus
);

  // One counter serves both the DATA wait and the TURN hold, so size it for the larger.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > TURN_CYCLES) ? TIMEOUT_CYCLES : TURN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_MAX    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

  lbus_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             nads_q, nads_d;
  logic             wnr_q, wnr_d;
  logic [5:0]       la_q, la_d;
  logic             ncs2_q, ncs2_d;
  logic             ncs3_q, ncs3_d;
  logic             nrd_q, nrd_d;
  logic [31:0]      ld_q, ld_d;
  logic             ld_oe_q, ld_oe_d;
  logic             nbterm_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    nads_d  = nads_q;
    wnr_d   = wnr_q;
    la_d    = la_q;
    ncs2_d  = ncs2_q;
    ncs3_d  = ncs3_q;
    nrd_d   = nrd_q;
    ld_d    = ld_q;
    ld_oe_d = ld_oe_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_i) begin
          state_d          = ST_ADDR;
          busy_d           = 1'b1;
          wr_d             = bus.wr_i;
          nads_d           = 1'b0;
          wnr_d            = bus.wr_i;
          la_d             = bus.addr_i;
          {ncs3_d, ncs2_d} = cs_decode(bus.space_i);
          if (bus.wr_i) begin
            ld_d    = bus.wdata_i;
            ld_oe_d = 1'b1;
          end
        end
      end

      ST_ADDR: begin
        state_d = ST_DATA;
        nads_d  = 1'b1;
        nrd_d   = wr_q;
        cnt_d   = '0;
      end

      ST_DATA: begin
        if (!bus.nREADY_i || cnt_q == TO_LAST) begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
          err_d   = bus.nREADY_i;
          nrd_d   = 1'b1;
          ncs2_d  = 1'b1;
          ncs3_d  = 1'b1;
          ld_oe_d = 1'b0;
          wnr_d   = 1'b0;
          if (!bus.nREADY_i && !wr_q) rdata_d = bus.LD_i;
        end
        if (bus.nREADY_i && cnt_q != TO_MAX) cnt_d = cnt_q + 1'b1;
      end

      ST_DONE: begin
        cnt_d = '0;
        if (!wr_q && (TURN_CYCLES > 0)) begin
          state_d = ST_TURN;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      ST_TURN: begin
        if (cnt_q == TURN_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Async reset so the bus is released the instant rst_i rises, even mid-cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      nads_q   <= 1'b1;
      wnr_q    <= 1'b0;
      la_q     <= '0;
      ncs2_q   <= 1'b1;
      ncs3_q   <= 1'b1;
      nrd_q    <= 1'b1;
      ld_q     <= '0;
      ld_oe_q  <= 1'b0;
      nbterm_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      nads_q   <= nads_d;
      wnr_q    <= wnr_d;
      la_q     <= la_d;
      ncs2_q   <= ncs2_d;
      ncs3_q   <= ncs3_d;
      nrd_q    <= nrd_d;
      ld_q     <= ld_d;
      ld_oe_q  <= ld_oe_d;
      nbterm_q <= bus.nBTERM_i;
    end
  end

  assign bus.busy_o       = busy_q;
  assign bus.ack_o        = ack_q;
  assign bus.err_o        = err_q;
  assign bus.rdata_o      = rdata_q;
  assign bus.nADS_o       = nads_q;
  assign bus.WnR_o        = wnr_q;
  assign bus.LA_o         = la_q;
  assign bus.nCS2_o       = ncs2_q;
  assign bus.nCS3_o       = ncs3_q;
  assign bus.nRD_o        = nrd_q;
  assign bus.LD_o         = ld_q;
  assign bus.LD_oe_o      = ld_oe_q;
  assign bus.nBTERM_dbg_o = nbterm_q;

endmodule

// File: tb/tb_surf_lbus_master.sv
// Bench for surf_lbus_master: behavioural SURF target with programmable wait states,
// directed scenarios, then randomized transactions checked against a memory model.
module tb_surf_lbus_master;
  import surf_lbus_master_pkg::*;

  localparam int TO   = 16;
  localparam int TURN = 1;

  logic clk;
  logic rst;
  surf_lbus_master_if bus();

  surf_lbus_master #(.TIMEOUT_CYCLES(TO), .TURN_CYCLES(TURN)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] seed_reg(input int i);
    if (i == 0) return IDENT_VALUE;
    if (i == 1) return 32'h0001_0000;
    return 32'hA000_0000 | 32'(i);
  endfunction

  function automatic logic [31:0] seed_hk(input int i);
    return 32'hB000_0000 | 32'(i);
  endfunction

  // Target model: arms on nADS, counts tgt_waits DATA edges, then pulses nREADY low.
  int          tgt_waits = 0;
  logic        tgt_never = 1'b0;
  logic        tgt_seeded = 1'b0;
  logic [31:0] tgt_reg [64];
  logic [31:0] tgt_hk  [64];
  logic [11:0] lab_cnt;
  logic        t_active;
  int          t_cnt;
  logic        t_wr;
  logic [5:0]  t_la;
  logic [1:0]  t_sp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.nREADY_i <= 1'b1;
      bus.LD_i     <= '0;
      t_active     <= 1'b0;
      t_cnt        <= 0;
      t_wr         <= 1'b0;
      t_la         <= '0;
      t_sp         <= '0;
      if (!tgt_seeded) begin
        for (int i = 0; i < 64; i++) begin
          tgt_reg[i] <= seed_reg(i);
          tgt_hk[i]  <= seed_hk(i);
        end
        lab_cnt    <= 12'h005;
        tgt_seeded <= 1'b1;
      end
    end else begin
      if (!bus.nREADY_i) begin
        bus.nREADY_i <= 1'b1;
        if (t_wr) begin
          if (t_sp == 2'd1) tgt_hk[t_la] <= bus.LD_o;
          else if (t_sp == 2'd0 && t_la > 6'd1) tgt_reg[t_la] <= bus.LD_o;
        end
      end
      if (!bus.nADS_o) begin
        t_active <= 1'b1;
        t_cnt    <= tgt_waits;
        t_wr     <= bus.WnR_o;
        t_la     <= bus.LA_o;
        t_sp     <= !bus.nCS2_o ? 2'd1 : (!bus.nCS3_o ? 2'd2 : 2'd0);
      end else if (bus.nRD_o && !bus.LD_oe_o) begin
        t_active <= 1'b0;
      end else if (t_active && !tgt_never) begin
        if (t_cnt == 0) begin
          bus.nREADY_i <= 1'b0;
          t_active     <= 1'b0;
          if (!t_wr) begin
            if (t_sp == 2'd1) bus.LD_i <= tgt_hk[t_la];
            else if (t_sp == 2'd2) begin
              bus.LD_i <= 32'h1AB0_0000 | 32'(lab_cnt);
              lab_cnt  <= lab_cnt + 12'd1;
            end else bus.LD_i <= tgt_reg[t_la];
          end
        end else begin
          t_cnt <= t_cnt - 1;
        end
      end
    end
  end

  // Reference model: what the target should hold and what the last good read returned.
  logic [31:0] ref_reg [64];
  logic [31:0] ref_hk  [64];
  logic [11:0] ref_lab;
  logic [31:0] ref_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy_o !== 1'b0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_idle", {31'd0, bus.busy_o}, 32'd0);
  endtask

  task automatic run_txn(input logic w, input logic [1:0] sp, input logic [5:0] a,
                         input logic [31:0] d, input int waits, input logic never);
    logic [31:0] exp_data;
    logic        exp_ncs2, exp_ncs3;
    int          n, exp_lat;
    exp_ncs2 = (sp != 2'd1);
    exp_ncs3 = (sp != 2'd2);
    if (sp == 2'd1)      exp_data = ref_hk[a];
    else if (sp == 2'd2) exp_data = 32'h1AB0_0000 | 32'(ref_lab);
    else                 exp_data = ref_reg[a];
    exp_lat = never ? TO + 1 : 3 + waits;

    wait_idle();
    tgt_waits   = waits;
    tgt_never   = never;
    bus.req_i   = 1'b1;
    bus.wr_i    = w;
    bus.space_i = sp;
    bus.addr_i  = a;
    bus.wdata_i = d;
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    chk("addr_busy", {31'd0, bus.busy_o}, 32'd1);
    chk("addr_nads", {31'd0, bus.nADS_o}, 32'd0);
    chk("addr_la",   {26'd0, bus.LA_o}, {26'd0, a});
    chk("addr_wnr",  {31'd0, bus.WnR_o}, {31'd0, w});
    chk("addr_cs",   {30'd0, bus.nCS3_o, bus.nCS2_o}, {30'd0, exp_ncs3, exp_ncs2});
    if (w) chk("addr_ld", bus.LD_o, d);
    chk("addr_ldoe", {31'd0, bus.LD_oe_o}, {31'd0, w});
    @(posedge clk); #1;
    n = 1;
    chk("data_strobes", {29'd0, bus.nADS_o, bus.nRD_o, bus.LD_oe_o}, {29'd0, 1'b1, w, w});
    while (bus.ack_o !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_latency", 32'(n), 32'(exp_lat));
    chk("err_flag", {31'd0, bus.err_o}, {31'd0, never});
    chk("released", {26'd0, bus.nCS2_o, bus.nCS3_o, bus.nRD_o, bus.LD_oe_o, bus.WnR_o, bus.nADS_o},
        32'b111001);
    if (!never) begin
      if (w) begin
        if (sp == 2'd1) ref_hk[a] = d;
        else if (sp != 2'd2 && a > 6'd1) ref_reg[a] = d;
      end else begin
        ref_rdata = exp_data;
        if (sp == 2'd2) ref_lab = ref_lab + 12'd1;
      end
    end
    chk("rdata", bus.rdata_o, ref_rdata);
    @(posedge clk); #1;
    chk("ack_pulse", {30'd0, bus.ack_o, bus.err_o}, 32'd0);
    chk("turn_busy", {31'd0, bus.busy_o}, {31'd0, ~w});
    if (!w) begin
      chk("turn_nads", {31'd0, bus.nADS_o}, 32'd1);
      @(posedge clk); #1;
      chk("turn_end", {31'd0, bus.busy_o}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, last, min_gap;
    rst          = 1'b1;
    bus.req_i    = 1'b0;
    bus.wr_i     = 1'b0;
    bus.space_i  = '0;
    bus.addr_i   = '0;
    bus.wdata_i  = '0;
    bus.nBTERM_i = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ref_reg[i] = seed_reg(i);
      ref_hk[i]  = seed_hk(i);
    end
    ref_lab   = 12'h005;
    ref_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {27'd0, bus.nADS_o, bus.nCS2_o, bus.nCS3_o, bus.nRD_o, bus.WnR_o}, 32'b11110);
    chk("rst_ctl", {29'd0, bus.busy_o, bus.ack_o, bus.err_o}, 32'd0);
    chk("rst_la", {26'd0, bus.LA_o}, 32'd0);
    chk("rst_ld", bus.LD_o, 32'd0);
    chk("rst_ldoe", {31'd0, bus.LD_oe_o}, 32'd0);
    chk("rst_rdata", bus.rdata_o, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    bus.nBTERM_i = 1'b0;
    @(posedge clk); #1;
    chk("bterm_dbg", {31'd0, bus.nBTERM_dbg_o}, 32'd0);
    bus.nBTERM_i = 1'b1;

    run_txn(1'b0, SPACE_REG, REG_IDENT, 32'd0, 0, 1'b0);
    chk("ident_value", bus.rdata_o, 32'h5355_5246);

    run_txn(1'b1, SPACE_REG, REG_MASK, 32'hDEAD_BEEF, 0, 1'b0);
    chk("short_mask", tgt_reg[7], 32'hDEAD_BEEF);
    run_txn(1'b0, SPACE_REG, REG_MASK, 32'd0, 1, 1'b0);
    chk("mask_readback", bus.rdata_o, 32'hDEAD_BEEF);

    run_txn(1'b0, SPACE_LAB, 6'd0, 32'd0, 0, 1'b0);
    chk("lab_rdata", bus.rdata_o, 32'h1AB0_0005);
    chk("lab_cnt_inc", {20'd0, lab_cnt}, 32'h006);

    run_txn(1'b0, SPACE_HK, 6'd3, 32'd0, 0, 1'b1);
    chk("timeout_rdata_kept", bus.rdata_o, 32'h1AB0_0005);

    // Async reset in the middle of a LAB read that would otherwise time out.
    wait_idle();
    tgt_never   = 1'b1;
    bus.req_i   = 1'b1;
    bus.wr_i    = 1'b0;
    bus.space_i = SPACE_LAB;
    bus.addr_i  = 6'd0;
    @(posedge clk); #1;
    bus.req_i = 1'b0;
    @(posedge clk); #1;
    chk("mid_read_strobes", {30'd0, bus.nRD_o, bus.nCS3_o}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_release", {27'd0, bus.nRD_o, bus.nCS2_o, bus.nCS3_o, bus.LD_oe_o, bus.busy_o}, 32'b11100);
    chk("async_no_ack", {31'd0, bus.ack_o}, 32'd0);
    @(posedge clk); #1;
    rst       = 1'b0;
    tgt_never = 1'b0;
    ref_rdata = '0;
    chk("post_rst_rdata", bus.rdata_o, 32'd0);
    @(posedge clk); #1;
    chk("post_rst_no_ack", {30'd0, bus.ack_o, bus.nADS_o}, 32'd1);
    run_txn(1'b0, SPACE_LAB, 6'd0, 32'd0, 2, 1'b0);
    chk("post_rst_lab", bus.rdata_o, 32'h1AB0_0006);

    // req_i held high: only three writes should issue, the rest are dropped while busy.
    wait_idle();
    tgt_waits   = 0;
    bus.req_i   = 1'b1;
    bus.wr_i    = 1'b1;
    bus.space_i = SPACE_REG;
    bus.addr_i  = 6'd9;
    bus.wdata_i = 32'h1234_5678;
    pulses  = 0;
    last    = -100;
    min_gap = 1000;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.nADS_o === 1'b0) begin
        pulses++;
        if (i - last < min_gap) min_gap = i - last;
        last = i;
        if (pulses == 3) bus.req_i = 1'b0;
      end
    end
    ref_reg[9] = 32'h1234_5678;
    chk("b2b_pulses", 32'(pulses), 32'd3);
    chk("b2b_spacing_ge4", {31'd0, (min_gap >= 4)}, 32'd1);
    run_txn(1'b0, SPACE_REG, 6'd9, 32'd0, 0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 15)),
              $urandom, int'($urandom_range(0, 6)), ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
